// File: rtl/key_debounce_scan.sv
// key_debounce_scan
// Conditions raw keyboard switch levels into a clean, debounced, active-high
// key-state vector. One integrator engine is time-multiplexed across all keys:
// on every sample tick the FSM snapshots the synchronized inputs, then walks
// the keys one per cycle, updating a saturating integrator and the debounced
// output bit with hysteresis.
//
// Ports:
//   clk_g_i       system clock, the only clock
//   rstn_g_i      synchronous reset, active-low
//   keys_i        raw asynchronous switch levels (NUM_KEYS bits)
//   keys_o        debounced key state, 1 = pressed
//   change_o      one-cycle pulse at end of a sweep that changed any keys_o bit
//   sweep_done_o  one-cycle pulse at end of every sweep
//   busy_o        high while a sweep is in progress (SNAP, SCAN, REPORT)
module key_debounce_scan #(
    parameter int NUM_KEYS   = 68,
    parameter int CNT_WIDTH  = 3,
    parameter int TICK_DIV   = 15000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk_g_i,
    input  logic                rstn_g_i,
    input  logic [NUM_KEYS-1:0] keys_i,
    output logic [NUM_KEYS-1:0] keys_o,
    output logic                change_o,
    output logic                sweep_done_o,
    output logic                busy_o
);

    localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int TCW   = $clog2(TICK_DIV);

    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_KEYS - 1);
    localparam logic [TCW-1:0]       TICK_LAST = TCW'(TICK_DIV - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    // Idle level of the raw inputs; synchronizers reset to it so no phantom
    // press is seen right after reset.
    localparam logic [NUM_KEYS-1:0]  REL_LVL   = {NUM_KEYS{(ACTIVE_LOW != 0)}};

    // A sweep must finish before the next tick arrives.
    if (TICK_DIV < NUM_KEYS + 4) begin : g_bad_tick_div
        $error("key_debounce_scan: TICK_DIV must be at least NUM_KEYS+4");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SNAP   = 2'd1,
        SCAN   = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t                 state_q;
    logic [NUM_KEYS-1:0]    sync1_q;
    logic [NUM_KEYS-1:0]    sync2_q;
    logic [NUM_KEYS-1:0]    norm_keys;
    logic [NUM_KEYS-1:0]    snap_q;
    logic [NUM_KEYS-1:0]    keys_q;
    logic [CNT_WIDTH-1:0]   cnt_q [NUM_KEYS];
    logic [TCW-1:0]         tick_cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   pending_q;
    logic                   changed_q;
    logic                   change_q;
    logic                   sweep_done_q;
    logic                   busy_q;
    logic                   tick;

    logic [CNT_WIDTH-1:0]   cnt_cur;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic                   key_cur;
    logic                   key_d;
    logic                   key_flip;

    // Polarity normalization: internally 1 always means pressed.
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_norm
        assign norm_keys[gi] = (ACTIVE_LOW != 0) ? ~sync2_q[gi] : sync2_q[gi];
    end

    assign tick = (tick_cnt_q == TICK_LAST);

    // Integrator and hysteresis for the key currently addressed by idx_q.
    always_comb begin
        cnt_cur = cnt_q[idx_q];
        cnt_d   = cnt_cur;
        if (snap_q[idx_q]) begin
            if (cnt_cur != CNT_MAX) cnt_d = cnt_cur + CNT_WIDTH'(1);
        end else begin
            if (cnt_cur != '0) cnt_d = cnt_cur - CNT_WIDTH'(1);
        end
        key_cur = keys_q[idx_q];
        key_d   = key_cur;
        if (cnt_d == CNT_MAX)  key_d = 1'b1;
        else if (cnt_d == '0)  key_d = 1'b0;
        key_flip = (key_d != key_cur);
    end

    always_ff @(posedge clk_g_i) begin
        if (!rstn_g_i) begin
            state_q      <= IDLE;
            sync1_q      <= REL_LVL;
            sync2_q      <= REL_LVL;
            snap_q       <= '0;
            keys_q       <= '0;
            tick_cnt_q   <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            changed_q    <= 1'b0;
            change_q     <= 1'b0;
            sweep_done_q <= 1'b0;
            busy_q       <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= keys_i;
            sync2_q <= sync1_q;

            // Free-running sample divider, independent of the FSM.
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TCW'(1);

            sweep_done_q <= 1'b0;
            change_q     <= 1'b0;

            // A tick landing mid-sweep is remembered (one deep) so it is not lost.
            if (tick && (state_q != IDLE)) pending_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (tick || pending_q) begin
                        state_q   <= SNAP;
                        pending_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                SNAP: begin
                    snap_q  <= norm_keys;
                    idx_q   <= '0;
                    state_q <= SCAN;
                end
                SCAN: begin
                    cnt_q[idx_q]  <= cnt_d;
                    keys_q[idx_q] <= key_d;
                    if (key_flip) changed_q <= 1'b1;
                    if (idx_q == LAST_IDX) begin
                        // Outputs are registered so they are high during REPORT;
                        // fold in a flip on the last key, which changed_q misses.
                        state_q      <= REPORT;
                        sweep_done_q <= 1'b1;
                        change_q     <= changed_q | key_flip;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                REPORT: begin
                    changed_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign keys_o       = keys_q;
    assign change_o     = change_q;
    assign sweep_done_o = sweep_done_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_key_debounce_scan.sv
// Testbench for key_debounce_scan (TICK_DIV shortened to 100).
// A table of {pressed keys, sweeps to hold, expected keys_o, expected change
// pulses, expected update offsets} drives most of the test; reset behaviour,
// sweep timing and the mid-sweep reset are hand-written sequences.
module tb_key_debounce_scan;

    localparam int NK = 68;
    localparam int TD = 100;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [NK-1:0] keys_i;
    logic [NK-1:0] keys_o;
    logic          change_o;
    logic          sweep_done_o;
    logic          busy_o;

    always #5 clk = ~clk;

    key_debounce_scan #(
        .NUM_KEYS  (NK),
        .CNT_WIDTH (3),
        .TICK_DIV  (TD),
        .ACTIVE_LOW(1)
    ) dut (
        .clk_g_i     (clk),
        .rstn_g_i    (rstn),
        .keys_i      (keys_i),
        .keys_o      (keys_o),
        .change_o    (change_o),
        .sweep_done_o(sweep_done_o),
        .busy_o      (busy_o)
    );

    int n_vec = 0;
    int n_bad = 0;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor (negedge): sweep/change counters, pulse spacing, and the offset
    // within a sweep (cycles since busy_o rose) at which each keys_o bit moved.
    int            sweep_cnt = 0;
    int            chg_cnt = 0;
    int            bad_chg = 0;
    int            spacing_bad = 0;
    int            prev_done = -1;
    int            off = 0;
    logic          busy_prev = 1'b0;
    logic [NK-1:0] last_keys = '0;
    int            chg_off [NK];

    always @(negedge clk) begin
        if (busy_o && !busy_prev) off = 0;
        else off++;
        for (int b = 0; b < NK; b++)
            if (keys_o[b] !== last_keys[b]) chg_off[b] = off;
        last_keys = keys_o;
        busy_prev = busy_o;
        if (change_o && !sweep_done_o) bad_chg++;
        if (change_o) chg_cnt++;
        if (sweep_done_o) begin
            if (prev_done >= 0 && (cyc - prev_done) != TD) spacing_bad++;
            prev_done = cyc;
            sweep_cnt++;
        end
    end

    task automatic check_vec(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_sweeps(input int n);
        int tgt;
        int c;
        tgt = sweep_cnt + n;
        c = 0;
        while (sweep_cnt < tgt && c < n * TD + 300) begin
            @(negedge clk);
            c++;
        end
        if (sweep_cnt < tgt) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_sweeps: got %0d sweeps, expected %0d within %0d cycles", sweep_cnt, tgt, c);
        end
    endtask

    typedef struct {
        logic [NK-1:0] press;
        int            sweeps;
        logic [NK-1:0] exp_keys;
        int            exp_chg;
        int            cb0;
        int            co0;
        int            cb1;
        int            co1;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [NK-1:0] press, input int sweeps,
                                input logic [NK-1:0] exp_keys, input int exp_chg,
                                input int cb0, input int co0, input int cb1, input int co1);
        vec_t v;
        v.press = press; v.sweeps = sweeps; v.exp_keys = exp_keys; v.exp_chg = exp_chg;
        v.cb0 = cb0; v.co0 = co0; v.cb1 = cb1; v.co1 = co1;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [NK-1:0] one;
        logic [NK-1:0] b0, b5, b10, b33, b67, lo30, lo40;
        int c0, c_rel, s0, n;

        one  = NK'(1);
        b0   = one;
        b5   = one << 5;
        b10  = one << 10;
        b33  = one << 33;
        b67  = one << 67;
        lo30 = (one << 30) - one;
        lo40 = (one << 40) - one;

        // Bounce on key 10 every sweep: integrator toggles 1,0,1,0...
        for (int i = 0; i < 50; i++)
            add((i % 2 == 0) ? b10 : '0, 1, '0, 0, -1, 0, -1, 0);
        // Integrator must have ended at 0: 6 press sweeps not enough, 7th sets.
        add(b10, 6, '0,  0, -1, 0, -1, 0);
        add(b10, 1, b10, 1, 10, 12, -1, 0);
        add('0,  6, b10, 0, -1, 0, -1, 0);
        add('0,  1, '0,  1, 10, 12, -1, 0);
        // Key 5 press, hold, release.
        add(b5,  6, '0, 0, -1, 0, -1, 0);
        add(b5,  1, b5, 1,  5, 7, -1, 0);
        add(b5,  5, b5, 0, -1, 0, -1, 0);
        add('0,  6, b5, 0, -1, 0, -1, 0);
        add('0,  1, '0, 1,  5, 7, -1, 0);
        // Keys 0 and 67 together: one change pulse, updates at their scan slots.
        add(b0 | b67, 6, '0,       0, -1, 0, -1, 0);
        add(b0 | b67, 1, b0 | b67, 1,  0, 2, 67, 69);
        // Hysteresis: partial presses/releases hold the outputs.
        add(b0 | b67 | b33, 3, b0 | b67, 0, -1, 0, -1, 0);
        add('0, 3, b0 | b67, 0, -1, 0, -1, 0);
        add('0, 3, b0 | b67, 0, -1, 0, -1, 0);
        add('0, 1, '0,       1,  0, 2, 67, 69);

        // Reset values.
        keys_i = '1;
        rstn   = 1'b0;
        repeat (3) @(negedge clk);
        check_vec("reset keys_o", keys_o, '0);
        check_int("reset change_o", int'(change_o), 0);
        check_int("reset sweep_done_o", int'(sweep_done_o), 0);
        check_int("reset busy_o", int'(busy_o), 0);
        rstn  = 1'b1;
        c_rel = cyc;

        // Idle run: 20 sweeps, first REPORT at cycle 169, then every 100 cycles.
        c0 = chg_cnt;
        wait_sweeps(20);
        check_int("idle 20th sweep_done cycle", prev_done - c_rel, 169 + 19 * TD);
        check_vec("idle keys_o", keys_o, '0);
        check_int("idle change pulses", chg_cnt - c0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            keys_i = ~tbl[i].press;
            c0 = chg_cnt;
            if (tbl[i].cb0 >= 0) chg_off[tbl[i].cb0] = -1;
            if (tbl[i].cb1 >= 0) chg_off[tbl[i].cb1] = -1;
            wait_sweeps(tbl[i].sweeps);
            check_vec($sformatf("v%0d keys_o", i), keys_o, tbl[i].exp_keys);
            check_int($sformatf("v%0d change pulses", i), chg_cnt - c0, tbl[i].exp_chg);
            if (tbl[i].cb0 >= 0)
                check_int($sformatf("v%0d key%0d offset", i, tbl[i].cb0), chg_off[tbl[i].cb0], tbl[i].co0);
            if (tbl[i].cb1 >= 0)
                check_int($sformatf("v%0d key%0d offset", i, tbl[i].cb1), chg_off[tbl[i].cb1], tbl[i].co1);
        end

        check_int("sweep_done spacing errors", spacing_bad, 0);
        check_int("change_o outside REPORT", bad_chg, 0);

        // Mid-sweep reset: keys 0..39 pressed from reset, reset when the 7th
        // sweep is at index 30 (keys 0..29 just set).
        rstn = 1'b0;
        @(negedge clk);
        keys_i = ~lo40;
        rstn = 1'b1;
        prev_done = -1;
        wait_sweeps(6);
        n = 0;
        while (!busy_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_int("7th sweep started", int'(busy_o), 1);
        repeat (31) @(negedge clk);
        check_vec("mid-sweep keys_o", keys_o, lo30);
        rstn = 1'b0;
        @(negedge clk);
        check_vec("abort keys_o", keys_o, '0);
        check_int("abort busy_o", int'(busy_o), 0);
        check_int("abort sweep_done_o", int'(sweep_done_o), 0);
        rstn = 1'b1;
        prev_done = -1;
        s0 = sweep_cnt;
        n = 0;
        while (!busy_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_int("first busy after reset", n, TD);
        check_int("no sweep_done after abort", sweep_cnt - s0, 0);
        wait_sweeps(1);
        check_vec("after abort one sweep keys_o", keys_o, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
